// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, Zicsr funct3 encodings, trap cause codes, mstatus bit
// positions and the sequencer state type.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
    localparam logic [11:0] CSR_CYCLE   = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH  = 12'hC80;

    // Zicsr funct3 encodings
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // mcause values
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;

    // mstatus bit indices (the only stored bits)
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Trap sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_e;

endpackage

// File: rtl/csr_trap_unit_alu.sv
// Combinational read-modify-write unit shared by every CSR. Produces the
// value to store and whether a store happens at all (set/clear forms with a
// zero rs1/zimm field are pure reads).
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1_field,
    output logic [XLEN-1:0] new_val,
    output logic            we
);

    // Select the update rule from funct3; reserved encodings never write.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        new_val = old_val;
        we      = 1'b0;
        unique case (funct3)
            F3_CSRRW, F3_CSRRWI: begin
                new_val = src;
                we      = 1'b1;
            end
            F3_CSRRS, F3_CSRRSI: begin
                new_val = old_val | src;
                we      = (rs1_field != 5'd0);
            end
            F3_CSRRC, F3_CSRRCI: begin
                new_val = old_val & ~src;
                we      = (rs1_field != 5'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the scpu writeback stage.
// Handles Zicsr reads/writes, ecall/illegal-instruction trap entry and mret
// with a one-cycle redirect to mepc.
// Optional macro CSR_MCYCLE_EN adds the 64-bit mcycle/cycle counter.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [31:0]     csr_inst,
    input  logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            trap_req,
    input  logic            trap_is_ecall,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_req,
    output logic [XLEN-1:0] mtvec_data,
    output logic [XLEN-1:0] mepc_data,
    output logic            set_pc_to_mepc,
    output logic            busy
);

    state_e          state_q, state_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef CSR_MCYCLE_EN
    logic [2*XLEN-1:0] mcycle_q, mcycle_d;
    logic [2*XLEN-1:0] mcycle_inc;
`endif

    logic [11:0]     csr_addr;
    logic [2:0]      funct3;
    logic [4:0]      rs1_field;
    logic [XLEN-1:0] csr_src;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] alu_new;
    logic            alu_we;
    logic            unused_inst_bits;

    assign csr_addr         = csr_inst[31:20];
    assign rs1_field        = csr_inst[19:15];
    assign funct3           = csr_inst[14:12];
    assign unused_inst_bits = ^csr_inst[11:0];
    assign csr_src          = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_field} : rs1_data;

    // Assemble mstatus from its two stored bits; everything else reads zero.
    always_comb begin
        mstatus_val               = '0;
        mstatus_val[MSTATUS_MIE]  = mie_q;
        mstatus_val[MSTATUS_MPIE] = mpie_q;
    end

    // Read mux: always the value held before any write at the coming edge.
    always_comb begin
        csr_old = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_old = mstatus_val;
            CSR_MTVEC:   csr_old = mtvec_q;
            CSR_MEPC:    csr_old = mepc_q;
            CSR_MCAUSE:  csr_old = mcause_q;
`ifdef CSR_MCYCLE_EN
            CSR_MCYCLE, CSR_CYCLE:   csr_old = mcycle_q[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH: csr_old = mcycle_q[2*XLEN-1:XLEN];
`endif
            default:     csr_old = '0;
        endcase
    end

    assign csr_rdata = csr_old;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .old_val   (csr_old),
        .src       (csr_src),
        .funct3    (funct3),
        .rs1_field (rs1_field),
        .new_val   (alu_new),
        .we        (alu_we)
    );

`ifdef CSR_MCYCLE_EN
    assign mcycle_inc = mcycle_q + 1'b1;
`endif

    // Next-state and register-update logic: trap beats mret beats CSR write,
    // and nothing is accepted outside IDLE.
    always_comb begin
        state_d  = state_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
`ifdef CSR_MCYCLE_EN
        mcycle_d = mcycle_inc;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (trap_req) begin
                    state_d  = ST_TRAP;
                    mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
                    mcause_d = trap_is_ecall ? CAUSE_ECALL_M : CAUSE_ILLEGAL;
                    mpie_d   = mie_q;
                    mie_d    = 1'b0;
                end else if (mret_req) begin
                    state_d  = ST_RET;
                    mie_d    = mpie_q;
                    mpie_d   = 1'b1;
                end else if (csr_valid && alu_we) begin
                    case (csr_addr)
                        CSR_MSTATUS: begin
                            mie_d  = alu_new[MSTATUS_MIE];
                            mpie_d = alu_new[MSTATUS_MPIE];
                        end
                        CSR_MTVEC:   mtvec_d  = {alu_new[XLEN-1:2], 2'b00};
                        CSR_MEPC:    mepc_d   = {alu_new[XLEN-1:2], 2'b00};
                        CSR_MCAUSE:  mcause_d = alu_new;
`ifdef CSR_MCYCLE_EN
                        // Low-half write suppresses the carry; high-half write
                        // still lets the low half count.
                        CSR_MCYCLE:  mcycle_d = {mcycle_q[2*XLEN-1:XLEN], alu_new};
                        CSR_MCYCLEH: mcycle_d = {alu_new, mcycle_inc[XLEN-1:0]};
`endif
                        default: ;
                    endcase
                end
            end
            ST_TRAP: state_d = ST_IDLE;
            ST_RET:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RESET;
            mepc_q   <= '0;
            mcause_q <= '0;
`ifdef CSR_MCYCLE_EN
            mcycle_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
`ifdef CSR_MCYCLE_EN
            mcycle_q <= mcycle_d;
`endif
        end
    end

    assign mtvec_data     = mtvec_q;
    assign mepc_data      = mepc_q;
    assign busy           = (state_q != ST_IDLE);
    // A reset landing in the RET cycle cancels the redirect.
    assign set_pc_to_mepc = (state_q == ST_RET) && !rst;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios followed by a
// randomized run against a behavioural model of the CSR/trap rules.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [31:0] csr_inst;
    logic [31:0] rs1_data;
    logic [31:0] csr_rdata;
    logic        trap_req;
    logic        trap_is_ecall;
    logic [31:0] trap_pc;
    logic        mret_req;
    logic [31:0] mtvec_data;
    logic [31:0] mepc_data;
    logic        set_pc_to_mepc;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_cyc;
    bit          m_busy, m_pulse;

    always #5 clk = ~clk;

    csr_trap_unit #(.XLEN(32), .MTVEC_RESET(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_valid      (csr_valid),
        .csr_inst       (csr_inst),
        .rs1_data       (rs1_data),
        .csr_rdata      (csr_rdata),
        .trap_req       (trap_req),
        .trap_is_ecall  (trap_is_ecall),
        .trap_pc        (trap_pc),
        .mret_req       (mret_req),
        .mtvec_data     (mtvec_data),
        .mepc_data      (mepc_data),
        .set_pc_to_mepc (set_pc_to_mepc),
        .busy           (busy)
    );

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [11:0] addr,
                                       input logic [4:0] field);
        return {addr, field, f3, 5'd1, 7'b1110011};
    endfunction

    task automatic clear_inputs();
        csr_valid     = 1'b0;
        csr_inst      = 32'h0;
        rs1_data      = 32'h0;
        trap_req      = 1'b0;
        trap_is_ecall = 1'b0;
        trap_pc       = 32'h0;
        mret_req      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef CSR_MCYCLE_EN
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_mstatus = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
        m_cyc = 0; m_busy = 0; m_pulse = 0;
    endtask

    task automatic m_step();
        logic [63:0] cyc_next;
        logic [31:0] old, src, nv;
        logic [11:0] a;
        logic [4:0]  fld;
        bit          do_wr;
        if (rst) begin
            m_reset();
            return;
        end
        cyc_next = m_cyc + 64'd1;
        a   = csr_inst[31:20];
        fld = csr_inst[19:15];
        if (m_busy) begin
            m_busy = 0; m_pulse = 0;
        end else if (trap_req) begin
            m_mepc    = trap_pc & ~32'h3;
            m_mcause  = trap_is_ecall ? 32'd11 : 32'd2;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            m_busy = 1; m_pulse = 0;
        end else if (mret_req) begin
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            m_busy = 1; m_pulse = 1;
        end else if (csr_valid) begin
            old   = m_read(a);
            src   = csr_inst[14] ? {27'd0, fld} : rs1_data;
            do_wr = 0;
            nv    = old;
            case (csr_inst[13:12])
                2'b01: begin do_wr = 1; nv = src; end
                2'b10: begin do_wr = (fld != 0); nv = old | src; end
                2'b11: begin do_wr = (fld != 0); nv = old & ~src; end
                default: ;
            endcase
            if (do_wr) begin
                case (a)
                    12'h300: m_mstatus = nv & 32'h88;
                    12'h305: m_mtvec   = nv & ~32'h3;
                    12'h341: m_mepc    = nv & ~32'h3;
                    12'h342: m_mcause  = nv;
                    12'hB00: cyc_next  = {m_cyc[63:32], nv};
                    12'hB80: cyc_next  = {nv, m_cyc[31:0] + 32'd1};
                    default: ;
                endcase
            end
        end
        m_cyc = cyc_next;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (mtvec_data !== 32'h0) begin n_err++; $display("FAIL reset_mtvec: got %h want %h", mtvec_data, 32'h0); end
        n_cmp++; if (mepc_data !== 32'h0) begin n_err++; $display("FAIL reset_mepc: got %h want %h", mepc_data, 32'h0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (set_pc_to_mepc !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b want 0", set_pc_to_mepc); end
        csr_inst = mk(3'b010, 12'h300, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL reset_mstatus: got %h want %h", csr_rdata, 32'h0); end
        csr_inst = mk(3'b010, 12'h342, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL reset_mcause: got %h want %h", csr_rdata, 32'h0); end
    endtask

    task automatic test_mtvec_write();
        clear_inputs();
        csr_valid = 1'b1;
        csr_inst  = mk(3'b001, 12'h305, 5'd1);
        rs1_data  = 32'h0000_0103;
        #1;
        n_cmp++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL mtvec_old_value: got %h want %h", csr_rdata, 32'h0); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (mtvec_data !== 32'h0000_0100) begin n_err++; $display("FAIL mtvec_write: got %h want %h", mtvec_data, 32'h100); end
    endtask

    task automatic test_trap();
        clear_inputs();
        csr_valid = 1'b1; csr_inst = mk(3'b001, 12'h300, 5'd1); rs1_data = 32'h8;
        tick();
        clear_inputs();
        trap_req = 1'b1; trap_is_ecall = 1'b1; trap_pc = 32'h0000_0046;
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL trap_busy: got %b want 1", busy); end
        n_cmp++; if (set_pc_to_mepc !== 1'b0) begin n_err++; $display("FAIL trap_no_pulse: got %b want 0", set_pc_to_mepc); end
        n_cmp++; if (mepc_data !== 32'h44) begin n_err++; $display("FAIL trap_mepc: got %h want %h", mepc_data, 32'h44); end
        csr_inst = mk(3'b010, 12'h342, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'd11) begin n_err++; $display("FAIL trap_mcause: got %h want %h", csr_rdata, 32'd11); end
        csr_inst = mk(3'b010, 12'h300, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h80) begin n_err++; $display("FAIL trap_mstatus: got %h want %h", csr_rdata, 32'h80); end
        tick();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL trap_busy_one_cycle: got %b want 0", busy); end
        n_cmp++; if (set_pc_to_mepc !== 1'b0) begin n_err++; $display("FAIL trap_settle_pulse: got %b want 0", set_pc_to_mepc); end
    endtask

    task automatic test_mret();
        clear_inputs();
        mret_req = 1'b1;
        #1;
        n_cmp++; if (set_pc_to_mepc !== 1'b0) begin n_err++; $display("FAIL mret_early_pulse: got %b want 0", set_pc_to_mepc); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (set_pc_to_mepc !== 1'b1) begin n_err++; $display("FAIL mret_pulse: got %b want 1", set_pc_to_mepc); end
        n_cmp++; if (mepc_data !== 32'h44) begin n_err++; $display("FAIL mret_mepc: got %h want %h", mepc_data, 32'h44); end
        csr_inst = mk(3'b010, 12'h300, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h88) begin n_err++; $display("FAIL mret_mstatus: got %h want %h", csr_rdata, 32'h88); end
        tick();
        #1;
        n_cmp++; if (set_pc_to_mepc !== 1'b0) begin n_err++; $display("FAIL mret_pulse_width: got %b want 0", set_pc_to_mepc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mret_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_set_clear();
        clear_inputs();
        trap_req = 1'b1; trap_is_ecall = 1'b0; trap_pc = 32'h0000_0100;
        tick();
        clear_inputs();
        tick();
        csr_valid = 1'b1; csr_inst = mk(3'b010, 12'h342, 5'd0); rs1_data = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (csr_rdata !== 32'h2) begin n_err++; $display("FAIL rs_zero_read: got %h want %h", csr_rdata, 32'h2); end
        tick();
        clear_inputs();
        csr_inst = mk(3'b010, 12'h342, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h2) begin n_err++; $display("FAIL rs_zero_nowrite: got %h want %h", csr_rdata, 32'h2); end
        csr_valid = 1'b1; csr_inst = mk(3'b001, 12'h300, 5'd1); rs1_data = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        csr_inst = mk(3'b010, 12'h300, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h88) begin n_err++; $display("FAIL mstatus_mask: got %h want %h", csr_rdata, 32'h88); end
        csr_valid = 1'b1; csr_inst = mk(3'b111, 12'h300, 5'd8);
        tick();
        clear_inputs();
        csr_inst = mk(3'b010, 12'h300, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h80) begin n_err++; $display("FAIL csrrci_mie: got %h want %h", csr_rdata, 32'h80); end
    endtask

    task automatic test_priority_and_reset();
        clear_inputs();
        trap_req = 1'b1; trap_is_ecall = 1'b1; trap_pc = 32'h0000_0203;
        mret_req = 1'b1;
        csr_valid = 1'b1; csr_inst = mk(3'b001, 12'h305, 5'd1); rs1_data = 32'h555;
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL prio_busy: got %b want 1", busy); end
        n_cmp++; if (set_pc_to_mepc !== 1'b0) begin n_err++; $display("FAIL prio_no_pulse: got %b want 0", set_pc_to_mepc); end
        n_cmp++; if (mepc_data !== 32'h200) begin n_err++; $display("FAIL prio_mepc: got %h want %h", mepc_data, 32'h200); end
        n_cmp++; if (mtvec_data !== 32'h100) begin n_err++; $display("FAIL prio_write_dropped: got %h want %h", mtvec_data, 32'h100); end
        tick();
        #1;
        n_cmp++; if (set_pc_to_mepc !== 1'b0) begin n_err++; $display("FAIL prio_settle_pulse: got %b want 0", set_pc_to_mepc); end
        mret_req = 1'b1;
        tick();
        clear_inputs();
        rst = 1'b1;
        #1;
        n_cmp++; if (set_pc_to_mepc !== 1'b0) begin n_err++; $display("FAIL ret_reset_pulse: got %b want 0", set_pc_to_mepc); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (set_pc_to_mepc !== 1'b0) begin n_err++; $display("FAIL ret_reset_after: got %b want 0", set_pc_to_mepc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ret_reset_busy: got %b want 0", busy); end
        n_cmp++; if (mtvec_data !== 32'h0) begin n_err++; $display("FAIL ret_reset_mtvec: got %h want %h", mtvec_data, 32'h0); end
        n_cmp++; if (mepc_data !== 32'h0) begin n_err++; $display("FAIL ret_reset_mepc: got %h want %h", mepc_data, 32'h0); end
        csr_inst = mk(3'b010, 12'h300, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL ret_reset_mstatus: got %h want %h", csr_rdata, 32'h0); end
        csr_inst = mk(3'b010, 12'h342, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL ret_reset_mcause: got %h want %h", csr_rdata, 32'h0); end
    endtask

    task automatic test_mcycle();
        clear_inputs();
        csr_valid = 1'b1; csr_inst = mk(3'b001, 12'hB00, 5'd1); rs1_data = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
`ifdef CSR_MCYCLE_EN
        csr_inst = mk(3'b010, 12'hB00, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mcycle_write: got %h want %h", csr_rdata, 32'hFFFF_FFFF); end
        csr_inst = mk(3'b010, 12'hB80, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL mcycleh_before: got %h want %h", csr_rdata, 32'h0); end
        tick();
        csr_inst = mk(3'b010, 12'hB00, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL mcycle_wrap: got %h want %h", csr_rdata, 32'h0); end
        csr_inst = mk(3'b010, 12'hB80, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h1) begin n_err++; $display("FAIL mcycleh_carry: got %h want %h", csr_rdata, 32'h1); end
        csr_inst = mk(3'b010, 12'hC80, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h1) begin n_err++; $display("FAIL cycleh_alias: got %h want %h", csr_rdata, 32'h1); end
`else
        csr_inst = mk(3'b010, 12'hB00, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL mcycle_absent: got %h want %h", csr_rdata, 32'h0); end
        csr_inst = mk(3'b010, 12'hC00, 5'd0); #1;
        n_cmp++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL cycle_absent: got %h want %h", csr_rdata, 32'h0); end
`endif
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        logic [2:0]  f3_tab [6]   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        logic [11:0] addr_tab [10] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00,
                                       12'hB80, 12'hC00, 12'hC80, 12'h301, 12'h344};
        logic [4:0]  fld;
        logic [31:0] exp_rd;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 600; i++) begin
            fld = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rst           = ($urandom_range(0, 63) == 0);
            trap_req      = ($urandom_range(0, 11) == 0);
            trap_is_ecall = 1'($urandom_range(0, 1));
            trap_pc       = $urandom;
            mret_req      = ($urandom_range(0, 9) == 0);
            csr_valid     = 1'($urandom_range(0, 1));
            rs1_data      = $urandom;
            csr_inst      = mk(f3_tab[$urandom_range(0, 5)], addr_tab[$urandom_range(0, 9)], fld);
            #1;
            exp_rd = m_read(csr_inst[31:20]);
            n_cmp++; if (csr_rdata !== exp_rd) begin n_err++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, csr_rdata, exp_rd); end
            n_cmp++; if (mtvec_data !== m_mtvec) begin n_err++; $display("FAIL rand_mtvec[%0d]: got %h want %h", i, mtvec_data, m_mtvec); end
            n_cmp++; if (mepc_data !== m_mepc) begin n_err++; $display("FAIL rand_mepc[%0d]: got %h want %h", i, mepc_data, m_mepc); end
            n_cmp++; if (busy !== m_busy) begin n_err++; $display("FAIL rand_busy[%0d]: got %b want %b", i, busy, m_busy); end
            n_cmp++; if (set_pc_to_mepc !== (m_pulse && !rst)) begin n_err++; $display("FAIL rand_pulse[%0d]: got %b want %b", i, set_pc_to_mepc, m_pulse && !rst); end
            @(posedge clk);
            m_step();
            @(negedge clk);
        end
        clear_inputs();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_mtvec_write();
        test_trap();
        test_mret();
        test_set_clear();
        test_priority_and_reset();
        test_mcycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Machine-mode CSR file and trap sequencer for the 5-stage scpu datapath. Executes Zicsr instructions at writeback. On ecall or illegal-instruction commit, records trap state in mepc, mcause and mstatus. On mret, restores mstatus and issues a one-cycle PC redirect to mepc. Feeds mtvec_data, mepc_data and set_pc_to_mepc to the PC register.

Parameters:
XLEN, 32, data width of every CSR.
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
csr_valid  in  1  WB-stage instruction is a Zicsr op (opcode 1110011, funct3≠000)
csr_inst  in  32  that instruction
rs1_data  in  32  rs1 operand value
csr_rdata  out  32  old CSR value, written to rd
trap_req  in  1  ecall or unimp committing at WB
trap_is_ecall  in  1  1 = ecall (cause 11), 0 = illegal instruction (cause 2)
trap_pc  in  32  PC of the trapping instruction
mret_req  in  1  mret committing at WB
mtvec_data  out  32  current mtvec
mepc_data  out  32  current mepc
set_pc_to_mepc  out  1  one-cycle redirect pulse
busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset, checked at posedge clk when rst=1:
  - mstatus, mepc, mcause → 0; mtvec → MTVEC_RESET.
  - set_pc_to_mepc → 0; busy → 0; FSM → IDLE.
  - Reset mid-sequence aborts the sequence; no pulse is emitted.
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] are stored; all other bits read 0.
  - mtvec 0x305: direct mode only; bits[1:0] forced to 0 on write.
  - mepc 0x341: bits[1:0] forced to 0.
  - mcause 0x342: full 32 bits.
  - Any other address reads 0; writes to it are ignored.
- Read path: csr_rdata is combinational from csr_inst[31:20] and the current register values. It always returns the pre-write value.
- Write path: takes effect at the posedge where csr_valid=1.
  - src = rs1_data for funct3 001/010/011; src = zero-extended csr_inst[19:15] for 101/110/111.
  - RW: new = src. RS: new = old | src. RC: new = old & ~src.
  - RS/RC with csr_inst[19:15]==0 perform no write.
- FSM states: IDLE, TRAP, RET.
  - IDLE + trap_req → TRAP. In the same edge: mepc ← trap_pc & ~3; mcause ← 11 or 2; MPIE ← MIE; MIE ← 0.
  - IDLE + mret_req → RET. In the same edge: MIE ← MPIE; MPIE ← 1.
  - RET: set_pc_to_mepc=1 for exactly this one cycle. mepc_data is stable and valid. Next state IDLE.
  - TRAP: one settle cycle with busy=1. Next state IDLE.
- Priority when events coincide: trap_req > mret_req > csr_valid. The lower-priority event is dropped, and the pipeline must not retire it.
- Events arriving while busy=1 are ignored. The pipeline guarantees none arrive.
- csr_valid in IDLE does not change the FSM state.
- mtvec_data and mepc_data are direct register outputs. A write is visible the cycle after its edge.

Optional Feature:
CSR_MCYCLE_EN.
- Defined:
  - Adds a 64-bit mcycle counter, incremented every cycle when not in reset; reset value 0.
  - Read/write as mcycle 0xB00 (low half) and mcycleh 0xB80 (high half).
  - A CSR write to either half replaces that half in place of the increment for that cycle. The increment carries into the high half except when the high half is being written.
  - Also readable as cycle 0xC00 and cycleh 0xC80 (read-only; writes ignored).
- Undefined: all of these addresses read 0 and writes are ignored; no counter logic is synthesized.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams;
  - funct3 encodings;
  - cause codes (ECALL_M=11, ILLEGAL=2);
  - mstatus bit indices MIE/MPIE;
  - the FSM state enum.
- Sub-module csr_alu: combinational; inputs old value, src and funct3; outputs new value and write-enable. Shared by all CSRs.

Test Plan:
- Reset, then csrrw x0, mtvec, rs1=0x0000_0103 → mtvec_data=0x0000_0100 the next cycle.
- mstatus=0x8 (MIE=1); trap_req, ecall, trap_pc=0x0000_0046 → mepc=0x44, mcause=11, mstatus=0x80, busy high for 1 cycle, set_pc_to_mepc stays 0.
- After that trap, mret_req → the next cycle has set_pc_to_mepc=1 for exactly 1 cycle with mepc_data=0x44, and mstatus=0x88.
- csrrs with rs1 field=0 on mcause=0x2 → csr_rdata=0x2, mcause unchanged; csrrci mstatus with zimm=8 → MIE cleared.
- trap_req, mret_req and csr_valid high in the same cycle → trap is taken, no pulse, CSR write dropped; then rst during RET → no pulse and all CSRs back at reset values.
- With CSR_MCYCLE_EN: write mcycle=0xFFFF_FFFF, then after 1 cycle mcycleh=1 and mcycle=0. Without it: reading 0xB00 gives 0.
